param_updown_counter: RTL and testbench

//  Parametrised up/down modulo counter. Successor to the fixed 4-bit down counter.

---
 rtl/param_updown_counter.sv | 80 ++++++++
 tb/tb_param_updown_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with prescaled enable, synchronous load,
// wrap/saturate ends, combinational terminal count and a registered wrap pulse.
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = MODULUS - 1,
    parameter int SATURATE  = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // A one-bit prescaler is kept even for PRESCALE=1; it then never leaves zero.
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt_reg, pre_cnt_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             step;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_reg == MAX_VAL);
    assign at_zero = (count_reg == '0);
    assign tc      = up_dn ? at_max : at_zero;
    assign step    = en && (pre_cnt_reg == PRE_LAST);

    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        count_next   = count_reg;
        wrap_next    = 1'b0;
        if (load) begin
            pre_cnt_next = '0;
            count_next   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            pre_cnt_next = '0;
            wrap_next    = tc;
            if (up_dn) begin
                if (!at_max)
                    count_next = count_reg + WIDTH'(1);
                else if (SATURATE == 0)
                    count_next = '0;
            end else begin
                if (!at_zero)
                    count_next = count_reg - WIDTH'(1);
                else if (SATURATE == 0)
                    count_next = MAX_VAL;
            end
        end else if (en) begin
            pre_cnt_next = pre_cnt_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_reg <= '0;
            count_reg   <= RST_VAL;
            wrap_reg    <= 1'b0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
            count_reg   <= count_next;
            wrap_reg    <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: four parameterisations share one stimulus
// stream, and each phase checks the instance it exercises at the negative edge.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] count_a, count_b, count_c, count_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       wrap_a, wrap_b, wrap_c, wrap_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_updown_counter dut_a (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );
    param_updown_counter #(.MODULUS(10)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );
    param_updown_counter #(.SATURATE(1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_c), .tc(tc_c), .wrap(wrap_c)
    );
    param_updown_counter #(.PRESCALE(3)) dut_d (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_d), .tc(tc_d), .wrap(wrap_d)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One clock: inputs were driven at a negedge, outputs are read at the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_count", 32'(count_a), 32'hF);
        check_val("rst_wrap",  32'(wrap_a),  32'h0);
        check_val("rst_tc",    32'(tc_a),    32'h1);
        check_val("rst_b_count", 32'(count_b), 32'h9);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_hold", 32'(count_a), 32'hF);
        end

        // Down count from F through 0, then wrap back to F
        up_dn = 1'b0; en = 1'b1;
        for (int i = 14; i >= 0; i--) begin
            tick();
            check_val("down_count", 32'(count_a), 32'(i));
            check_val("down_wrap0", 32'(wrap_a), 32'h0);
        end
        check_val("down_tc_at0", 32'(tc_a), 32'h1);
        tick();
        check_val("down_wrapF", 32'(count_a), 32'hF);
        check_val("down_wrap1", 32'(wrap_a), 32'h1);
        tick();
        check_val("down_afterE", 32'(count_a), 32'hE);
        check_val("down_wrap_clr", 32'(wrap_a), 32'h0);

        // MODULUS=10: clamped load (with en high, load must win), then up wrap
        up_dn = 1'b1; load = 1'b1; load_val = 4'd13;
        tick();
        load = 1'b0;
        check_val("m10_clamp", 32'(count_b), 32'h9);
        check_val("m10_tc9", 32'(tc_b), 32'h1);
        check_val("m10_wrap_ld", 32'(wrap_b), 32'h0);
        tick();
        check_val("m10_wrap0", 32'(count_b), 32'h0);
        check_val("m10_wrap1", 32'(wrap_b), 32'h1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check_val("m10_up", 32'(count_b), 32'(i));
            check_val("m10_nowrap", 32'(wrap_b), 32'h0);
        end
        check_val("m10_tc_end", 32'(tc_b), 32'h1);

        // Saturating up count from 14
        en = 1'b0; load = 1'b1; load_val = 4'd14;
        tick();
        load = 1'b0;
        check_val("sat_load", 32'(count_c), 32'hE);
        en = 1'b1;
        tick();
        check_val("sat_reach", 32'(count_c), 32'hF);
        check_val("sat_reach_wrap", 32'(wrap_c), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("sat_hold", 32'(count_c), 32'hF);
            check_val("sat_pulse", 32'(wrap_c), 32'h1);
        end
        en = 1'b0;
        tick();
        check_val("sat_idle_wrap", 32'(wrap_c), 32'h0);

        // PRESCALE=3: phase freezes with en low, load restarts the phase
        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); check_val("pre_p1", 32'(count_d), 32'h0);
        tick(); check_val("pre_p2", 32'(count_d), 32'h0);
        tick(); check_val("pre_step1", 32'(count_d), 32'h1);
        tick(); check_val("pre_p1b", 32'(count_d), 32'h1);
        en = 1'b0;
        tick(); tick();
        check_val("pre_frozen", 32'(count_d), 32'h1);
        en = 1'b1;
        tick(); check_val("pre_p2b", 32'(count_d), 32'h1);
        tick(); check_val("pre_step2", 32'(count_d), 32'h2);
        tick(); check_val("pre_p1c", 32'(count_d), 32'h2);
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0;
        check_val("pre_load", 32'(count_d), 32'h5);
        tick(); check_val("pre_rs1", 32'(count_d), 32'h5);
        tick(); check_val("pre_rs2", 32'(count_d), 32'h5);
        tick(); check_val("pre_rs_step", 32'(count_d), 32'h6);

        // Asynchronous reset between edges, then load beats a coincident step
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        check_val("mid_load7", 32'(count_a), 32'h7);
        #2 rstn = 1'b0;
        #1 check_val("async_rst", 32'(count_a), 32'hF);
        @(negedge clk);
        rstn = 1'b1;
        up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0; en = 1'b0;
        check_val("load_wins", 32'(count_a), 32'h3);
        check_val("load_nowrap", 32'(wrap_a), 32'h0);
        up_dn = 1'b0;
        #1 check_val("tc_dn_nz", 32'(tc_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
